booth_datapath: RTL

- Radix-4 Booth multiplier datapath, directly downstream of the CU.
- Consumes CU control strobes (load, muxsel, ALUop, shift_direction, shift_amount, out_enable).
- Returns recoding/status bits to the CU on cmp0/cmp1.
- Holds accumulator A, multiplier Q, bit q_m1, multiplicand M and an iteration counter; registers the signed product and pulses product_valid.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_alu.sv | 30 +++
 rtl/booth_datapath.sv | 125 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared constants and width helpers for the radix-4 Booth multiplier datapath.
// ALU operation codes, shift directions and the QW/AW width derivations.
package booth_pkg;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_ADD_M  = 3'b001;
   localparam logic [2:0] OP_ADD_2M = 3'b010;
   localparam logic [2:0] OP_SUB_M  = 3'b011;
   localparam logic [2:0] OP_SUB_2M = 3'b100;

   localparam logic SH_LEFT  = 1'b0;
   localparam logic SH_RIGHT = 1'b1;

   // Q is padded to an even width so radix-4 steps consume it exactly.
   function automatic int calc_qw(input int width);
      return width + (width % 2);
   endfunction

   // A needs two guard bits to hold +/-2M without overflow.
   function automatic int calc_aw(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/booth_alu.sv
// Combinational AW-bit accumulator update for the Booth datapath.
// Selects A, A+M, A+2M, A-M or A-2M; unassigned codes return A unchanged.
module booth_alu
   import booth_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] a,
   input  logic [AW-1:0] m,
   input  logic [2:0]    op,
   output logic [AW-1:0] y
);

   logic [AW-1:0] m_x2;

   assign m_x2 = {m[AW-2:0], 1'b0};

   // NOTE: y gets its default before the case so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      y = a;
      case (op)
         OP_ADD_M:  y = a + m;
         OP_ADD_2M: y = a + m_x2;
         OP_SUB_M:  y = a - m;
         OP_SUB_2M: y = a - m_x2;
         default:   y = a;
      endcase
   end

endmodule

// File: rtl/booth_datapath.sv
// Radix-4 Booth multiplier datapath: A/Q/q_m1/M registers, shifter, counter, product capture.
// Optional sticky illegal-ALUop flag 'err' is built when BOOTH_ILLEGAL_OP_EN is defined.
module booth_datapath
   import booth_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int CNT_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               load,
   input  logic               muxsel,
   input  logic [2:0]         ALUop,
   input  logic               shift_direction,
   input  logic [2:0]         shift_amount,
   input  logic               out_enable,
   output logic [2:0]         cmp0,
   output logic [2:0]         cmp1,
   output logic [2*WIDTH-1:0] product,
   output logic               product_valid
`ifdef BOOTH_ILLEGAL_OP_EN
   ,
   output logic               err
`endif
);

   localparam int QW = calc_qw(WIDTH);
   localparam int AW = calc_aw(WIDTH);
   localparam int VW = AW + QW + 1;
   localparam int PW = 2 * WIDTH;

   logic [AW-1:0]         a_r;
   logic [AW-1:0]         m_r;
   logic [QW-1:0]         q_r;
   logic                  qm1_r;
   logic [CNT_W-1:0]      count_r;

   logic [AW-1:0]         alu_y;
   logic [AW-1:0]         a_upd;
   logic [VW-1:0]         vec;
   logic [VW-1:0]         vec_sh;
   logic [AW+QW-1:0]      aq;
   logic signed [QW-1:0]  q_ext;
   logic signed [AW-1:0]  m_ext;
   logic                  done;
   logic                  count_step;

   booth_alu #(.AW(AW)) u_alu (
      .a  (a_r),
      .m  (m_r),
      .op (ALUop),
      .y  (alu_y)
   );

   assign q_ext = $signed(multiplier);
   assign m_ext = $signed(multiplicand);

   assign a_upd = muxsel ? '0 : alu_y;
   assign vec   = {a_upd, q_r, qm1_r};

   // Right shifts are arithmetic on the whole {A,Q,q_m1} vector; left shifts zero-fill at q_m1.
   always_comb begin
      vec_sh = vec;
      if (shift_direction == SH_RIGHT)
         vec_sh = $signed(vec) >>> shift_amount;
      else
         vec_sh = vec << shift_amount;
   end

   assign count_step = (shift_amount != 3'd0) && (shift_direction == SH_RIGHT);
   assign aq         = {a_r, q_r};

   assign done = (count_r == CNT_W'(QW / 2));
   assign cmp0 = {q_r[1], q_r[0], qm1_r};
   assign cmp1 = {done, 2'(count_r)};

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         q_r     <= '0;
         qm1_r   <= 1'b0;
         m_r     <= '0;
         count_r <= '0;
      end else if (load) begin
         a_r     <= '0;
         q_r     <= q_ext;
         qm1_r   <= 1'b0;
         m_r     <= m_ext;
         count_r <= '0;
      end else begin
         {a_r, q_r, qm1_r} <= vec_sh;
         if (count_step)
            count_r <= count_r + CNT_W'(1);
      end
   end

   // A load suppresses the capture itself, but the CU still gets its out_enable acknowledgement.
   always_ff @(posedge clk) begin
      if (rst) begin
         product       <= '0;
         product_valid <= 1'b0;
      end else begin
         product_valid <= out_enable;
         if (out_enable && !load)
            product <= aq[PW-1:0];
      end
   end

`ifdef BOOTH_ILLEGAL_OP_EN
   logic op_illegal;

   assign op_illegal = (ALUop > OP_SUB_2M);

   always_ff @(posedge clk) begin
      if (rst || load)
         err <= 1'b0;
      else if (op_illegal && !muxsel)
         err <= 1'b1;
   end
`endif

endmodule
